csr_wr_sched: RTL
=================

// Module: csr_wr_sched
// PURPOSE
//  Buffers CSR write requests retiring from the two writeback lanes and drains them, one per
//  cycle and in program order, onto the single CSR-file write port (csr_we/csr_addr/csr_wdata).
//  It sits between WB and the CSR file. It lets both lanes retire CSR writes in the same cycle.
//  It back-pressures WB through in_ready when it cannot take a full lane pair.
// PARAMETERS
//  DEPTH    4   queue entries; power of two, >= 2
//  AW       14  CSR address width
//  DW       32  CSR data width
// PORTS
//  clk         in   1    clock, all state on rising edge
//  reset       in   1    asynchronous, active-high; clears all state
//  in_valid1   in   1    lane-1 (older) CSR write request
//  in_addr1    in   AW   lane-1 CSR address
//  in_wdata1   in   DW   lane-1 CSR write data
//  in_valid2   in   1    lane-2 (younger) CSR write request
//  in_addr2    in   AW   lane-2 CSR address
//  in_wdata2   in   DW   lane-2 CSR write data
//  in_ready    out  1    scheduler can accept any valid lane pair this cycle
//  csr_we      out  1    CSR-file write enable (head entry valid)
//  csr_addr    out  AW   CSR-file write address
//  csr_wdata   out  DW   CSR-file write data
//  pending     out  $clog2(DEPTH)+1  occupied entries
//  empty       out  1    pending == 0
// BEHAVIOUR
//  - Storage: circular queue of DEPTH {addr,data} entries. Read/write pointers are
//    $clog2(DEPTH) bits and wrap modulo DEPTH. The count register is $clog2(DEPTH)+1 bits.
//  - Reset (async): pointers=0, count=0. The CSR port therefore reads csr_we=0, csr_addr=0,
//    csr_wdata=0, with pending=0, empty=1 and in_ready=1. Entry storage is not cleared.
//    Reset asserted mid-drain discards all queued writes with no partial write.
//  - in_ready = (DEPTH - count) >= 2. It is computed from registered count only. It ignores
//    a same-cycle pop, and this conservative rule is intentional.
//  - Accept: a lane is enqueued on a rising edge when its in_valid is 1 and in_ready is 1.
//    Lane 1 takes the write-pointer slot and lane 2 takes the next slot.
//    If only lane 2 is valid, it takes the write-pointer slot.
//    Valid lanes with in_ready=0 are ignored; WB must hold them.
//  - Same address on both lanes: both entries are enqueued in order, so lane 2's data wins
//    in the CSR. No merging is done.
//  - Drain: csr_we = !empty, and {csr_addr,csr_wdata} = head entry. These outputs are
//    combinational from registers, with no input-to-output path. When empty, csr_addr and
//    csr_wdata are driven to 0.
//    A pop occurs on every edge where csr_we=1, because the CSR file always accepts.
//  - Latency: a request accepted at edge N appears on the CSR port in cycle N+1 (if the queue
//    was empty) and is written at edge N+1. Throughput is 1 write per cycle.
//  - Simultaneous push and pop: count_next = count + pushes - pop, where pushes is 0..2 and
//    pop is 0..1. The count never exceeds DEPTH and never underflows.
// CONFIGURATION
//  CSR_WR_FWD_EN defined: adds ports fwd_raddr (in, AW), fwd_hit (out, 1) and fwd_rdata
//    (out, DW).
//    - fwd_hit=1 when any occupied entry (head included) has addr == fwd_raddr.
//    - fwd_rdata is the data of the youngest matching entry. It is combinational and
//      excludes this cycle's inputs.
//    - When fwd_hit=0, fwd_rdata is 0. Lets EX read CSR values not yet written.
//  CSR_WR_FWD_EN undefined: those ports and the compare logic do not exist.
//    EX must stall on !empty before reading a CSR.
// TESTING
//  1 Reset, then idle -> csr_we=0, pending=0, empty=1, in_ready=1 for 10 cycles.
//  2 Lane1 only {0x006, 0xDEADBEEF} -> next cycle csr_we=1, addr 0x006, data 0xDEADBEEF;
//    the cycle after, csr_we=0.
//  3 Both lanes {0x001,0x11} and {0x002,0x22} in one cycle -> consecutive cycles drive
//    0x001/0x11 then 0x002/0x22; pending goes 2,1,0.
//  4 Both lanes valid every cycle with DEPTH=4 -> in_ready drops when count=3 or 4, no
//    entry is lost or duplicated, and drain order equals issue order through pointer wraps.
//  5 Same addr 0x005 on both lanes, data 0xA then 0xB -> two writes to 0x005, 0xA then 0xB.
//  6 Assert reset with 3 entries queued -> csr_we=0 immediately (async), pending=0.
//    With CSR_WR_FWD_EN: queue {0x7,0x1} then {0x7,0x2} and probe fwd_raddr=0x7 ->
//    fwd_hit=1, fwd_rdata=0x2.

Source files
------------

// File: rtl/csr_wr_sched.sv
// csr_wr_sched
// Collects CSR write requests retiring from the two writeback lanes and drains
// them in program order onto the single CSR-file write port, one per cycle.
//
// Optional feature macro: CSR_WR_FWD_EN
//   When defined, adds fwd_raddr/fwd_hit/fwd_rdata. These let EX read a CSR
//   value that is still queued. When undefined, those ports and the compare
//   logic are absent, and EX must stall on !empty before reading a CSR.
//
// Ports
//   clk, reset                 clock; asynchronous active-high reset
//   in_valid1/in_addr1/in_wdata1  lane-1 (older) write request
//   in_valid2/in_addr2/in_wdata2  lane-2 (younger) write request
//   in_ready                   room for a full lane pair (from registered count)
//   csr_we/csr_addr/csr_wdata  head entry presented to the CSR file
//   pending, empty             occupancy
//   fwd_raddr/fwd_hit/fwd_rdata   (CSR_WR_FWD_EN only) youngest queued match
module csr_wr_sched #(
    parameter int DEPTH = 4,
    parameter int AW    = 14,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid1,
    input  logic [AW-1:0]            in_addr1,
    input  logic [DW-1:0]            in_wdata1,
    input  logic                     in_valid2,
    input  logic [AW-1:0]            in_addr2,
    input  logic [DW-1:0]            in_wdata2,
    output logic                     in_ready,
    output logic                     csr_we,
    output logic [AW-1:0]            csr_addr,
    output logic [DW-1:0]            csr_wdata,
    output logic [$clog2(DEPTH):0]   pending,
`ifdef CSR_WR_FWD_EN
    input  logic [AW-1:0]            fwd_raddr,
    output logic                     fwd_hit,
    output logic [DW-1:0]            fwd_rdata,
`endif
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg,  count_next;

    logic          push1, push2, pop;
    logic [PW-1:0] slot2;

    // Readiness looks only at the registered count, so a pop in the same
    // cycle never frees room early; this keeps in_ready off any input path.
    assign in_ready = (count_reg <= READY_MAX);
    assign push1    = in_valid1 & in_ready;
    assign push2    = in_valid2 & in_ready;
    assign pop      = (count_reg != '0);

    // Lane 2 follows lane 1 when both push, otherwise it takes the tail slot.
    assign slot2 = push1 ? (wr_ptr_reg + PW'(1)) : wr_ptr_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg + PW'(push1) + PW'(push2);
        rd_ptr_next = rd_ptr_reg + PW'(pop);
        count_next  = count_reg + CW'(push1) + CW'(push2) - CW'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Entry storage is never cleared; occupancy is tracked by the pointers.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push1 && (wr_ptr_reg == PW'(gi))) begin
                    addr_mem[gi] <= in_addr1;
                    data_mem[gi] <= in_wdata1;
                end else if (push2 && (slot2 == PW'(gi))) begin
                    addr_mem[gi] <= in_addr2;
                    data_mem[gi] <= in_wdata2;
                end
            end
        end
    endgenerate

    assign csr_we    = pop;
    assign csr_addr  = pop ? addr_mem[rd_ptr_reg] : '0;
    assign csr_wdata = pop ? data_mem[rd_ptr_reg] : '0;
    assign pending   = count_reg;
    assign empty     = (count_reg == '0);

`ifdef CSR_WR_FWD_EN
    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        logic [PW-1:0] idx;
        fwd_hit   = 1'b0;
        fwd_rdata = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_reg + PW'(i);
            if ((CW'(i) < count_reg) && (addr_mem[idx] == fwd_raddr)) begin
                fwd_hit   = 1'b1;
                fwd_rdata = data_mem[idx];
            end
        end
    end
`endif

endmodule
